ls240_bus_arbiter: RTL and testbench



---
 rtl/ls240_bus_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_ls240_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls240_bus_arbiter.sv
// ls240_bus_arbiter
//   Round-robin arbiter that shares one tristate bus between NREQ requesters.
//   Each requester drives the bus through its own sn74ls240-style octal
//   buffer. The active-low gnt_/oe_ strobes go to the buffers' g1_/g2_ pins.
//   Between two owners there are always at least DEAD cycles in which no
//   buffer drives the bus (break-before-make).
//
//   Optional feature (macro ARB_HOLD_LIMIT_EN): the owner is forced off the
//   bus after MAXHOLD ownership cycles, but only if another requester is
//   waiting. Without the macro there is no tenure limit and no tenure counter.
//
// Ports
//   clk    in   1     rising-edge clock
//   clr_   in   1     asynchronous active-low reset
//   req_   in   NREQ  active-low bus requests (X/Z counts as not requesting)
//   gnt_   out  NREQ  active-low grant, one-hot-low or all high
//   oe_    out  NREQ  active-low buffer output enable, one-hot-low or all high
//   busy   out  1     high while a requester is in turnaround or owns the bus
//   owner  out  OWNW  index of the granted requester, 0 when idle
module ls240_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int DEAD    = 1,
`ifdef ARB_HOLD_LIMIT_EN
  parameter int MAXHOLD = 8,
`endif
  parameter int OWNW    = 2
) (
  input  logic            clk,
  input  logic            clr_,
  input  logic [NREQ-1:0] req_,
  output logic [NREQ-1:0] gnt_,
  output logic [NREQ-1:0] oe_,
  output logic            busy,
  output logic [OWNW-1:0] owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [OWNW-1:0] win_r, win_nxt_s;
  logic [OWNW-1:0] ptr_r, ptr_nxt_s;
  logic [OWNW-1:0] pick_s;
  logic [3:0]      dead_r, dead_nxt_s;
  logic [NREQ-1:0] act_s, others_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic [NREQ-1:0] oe_r, oe_nxt_s;
  logic            busy_r;
  logic [OWNW-1:0] owner_r;
  logic            win_act_s;
  logic            rel_s;
`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0]      ten_r, ten_nxt_s;
`endif

  // One-hot bit for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [OWNW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // First active requester searching upward from ptr, wrapping modulo NREQ.
  function automatic logic [OWNW-1:0] rr_pick(input logic [NREQ-1:0] act,
                                              input logic [OWNW-1:0] ptr);
    logic            found;
    int              idx;
    logic [NREQ-1:0] sh;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      sh  = act >> idx;
      if (!found && sh[0]) begin
        rr_pick = OWNW'(idx);
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Only a clean low counts as a request; X or Z is ignored.
  for (genvar g = 0; g < NREQ; g++) begin : g_act
    assign act_s[g] = (req_[g] === 1'b0);
  end

  assign win_act_s = |(act_s & onehot(win_r));
  assign others_s  = act_s & ~onehot(win_r);
  // After entering OWN the pointer sits just past the owner, so the owner
  // is last in line; picking over all requests never re-selects a preempted
  // owner while someone else is waiting.
  assign pick_s    = rr_pick(act_s, ptr_r);

`ifdef ARB_HOLD_LIMIT_EN
  // >= rather than == so a requester arriving after the limit still preempts.
  assign rel_s = !win_act_s || ((ten_r >= 8'(MAXHOLD)) && (|others_s));
`else
  assign rel_s = !win_act_s;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s = state_r;
    win_nxt_s   = win_r;
    ptr_nxt_s   = ptr_r;
    dead_nxt_s  = dead_r;
    gnt_nxt_s   = '1;
    oe_nxt_s    = '1;
`ifdef ARB_HOLD_LIMIT_EN
    ten_nxt_s   = ten_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (|act_s) begin
          state_nxt_s = ST_TURN;
          win_nxt_s   = pick_s;
          gnt_nxt_s   = ~onehot(pick_s);
          dead_nxt_s  = 4'(DEAD);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (!win_act_s) begin
          // Winner withdrew before driving: hand over or go idle.
          if (|act_s) begin
            state_nxt_s = ST_TURN;
            win_nxt_s   = pick_s;
            gnt_nxt_s   = ~onehot(pick_s);
            dead_nxt_s  = 4'(DEAD);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (dead_r == 4'd1) begin
          state_nxt_s = ST_OWN;
          gnt_nxt_s   = ~onehot(win_r);
          oe_nxt_s    = ~onehot(win_r);
          ptr_nxt_s   = (win_r == OWNW'(NREQ - 1)) ? '0 : win_r + OWNW'(1);
`ifdef ARB_HOLD_LIMIT_EN
          ten_nxt_s   = 8'd1;
`endif
        end else begin
          dead_nxt_s = dead_r - 4'd1;
          gnt_nxt_s  = ~onehot(win_r);
        end
      end
      ST_OWN: begin
        if (rel_s) begin
          if (|others_s) begin
            state_nxt_s = ST_TURN;
            win_nxt_s   = pick_s;
            gnt_nxt_s   = ~onehot(pick_s);
            dead_nxt_s  = 4'(DEAD);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          gnt_nxt_s = ~onehot(win_r);
          oe_nxt_s  = ~onehot(win_r);
`ifdef ARB_HOLD_LIMIT_EN
          ten_nxt_s = (ten_r == 8'd255) ? ten_r : ten_r + 8'd1;
`endif
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; clr_ releases the bus at once.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_r <= ST_IDLE;
      win_r   <= '0;
      ptr_r   <= '0;
      dead_r  <= 4'd0;
      gnt_r   <= '1;
      oe_r    <= '1;
      busy_r  <= 1'b0;
      owner_r <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      ten_r   <= 8'd0;
`endif
    end else begin
      state_r <= state_nxt_s;
      win_r   <= win_nxt_s;
      ptr_r   <= ptr_nxt_s;
      dead_r  <= dead_nxt_s;
      gnt_r   <= gnt_nxt_s;
      oe_r    <= oe_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      owner_r <= (state_nxt_s == ST_IDLE) ? '0 : win_nxt_s;
`ifdef ARB_HOLD_LIMIT_EN
      ten_r   <= ten_nxt_s;
`endif
    end
  end

  assign gnt_  = gnt_r;
  assign oe_   = oe_r;
  assign busy  = busy_r;
  assign owner = owner_r;

endmodule

// File: tb/tb_ls240_bus_arbiter.sv
// Self-checking bench for ls240_bus_arbiter (NREQ=4, DEAD=1; MAXHOLD=4 when
// ARB_HOLD_LIMIT_EN is defined). Directed scenarios use constant expectations;
// the random phase compares against a requester/owner/countdown model.
module tb_ls240_bus_arbiter;
  localparam int NREQ = 4;
  localparam int DEAD = 1;
  localparam int OWNW = 2;
`ifdef ARB_HOLD_LIMIT_EN
  localparam int MAXHOLD = 4;
`endif

  logic            clk  = 1'b0;
  logic            clr_ = 1'b1;
  logic [NREQ-1:0] req_ = 4'b1111;
  logic [NREQ-1:0] gnt_;
  logic [NREQ-1:0] oe_;
  logic            busy;
  logic [OWNW-1:0] owner;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds the grant (-1 none), whether it is driving,
  // turnaround cycles left, round-robin start index, ownership cycle count.
  int m_w    = -1;
  bit m_drv  = 1'b0;
  int m_left = 0;
  int m_ptr  = 0;
  int m_ten  = 0;

  always #5 clk = ~clk;

  ls240_bus_arbiter #(
    .NREQ(NREQ),
    .DEAD(DEAD),
`ifdef ARB_HOLD_LIMIT_EN
    .MAXHOLD(MAXHOLD),
`endif
    .OWNW(OWNW)
  ) dut (
    .clk(clk),
    .clr_(clr_),
    .req_(req_),
    .gnt_(gnt_),
    .oe_(oe_),
    .busy(busy),
    .owner(owner)
  );

  function automatic bit has(input logic [NREQ-1:0] a, input int i);
    logic [NREQ-1:0] sh;
    sh = a >> i;
    return sh[0];
  endfunction

  function automatic int first_from(input logic [NREQ-1:0] a, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (has(a, (p + k) % NREQ)) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_w = -1; m_drv = 1'b0; m_left = 0; m_ptr = 0; m_ten = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] a);
    bit drop;
`ifdef ARB_HOLD_LIMIT_EN
    logic [NREQ-1:0] others;
`endif
    if (m_w < 0) begin
      m_w = first_from(a, m_ptr);
      m_left = DEAD;
      m_drv = 1'b0;
    end else if (!m_drv) begin
      if (!has(a, m_w)) begin
        m_w = first_from(a, m_ptr);
        m_left = DEAD;
      end else if (m_left == 1) begin
        m_drv = 1'b1;
        m_ptr = (m_w + 1) % NREQ;
        m_ten = 1;
      end else begin
        m_left--;
      end
    end else begin
      drop = !has(a, m_w);
`ifdef ARB_HOLD_LIMIT_EN
      others = a & ~(4'b0001 << m_w);
      if (m_ten >= MAXHOLD && others != 4'b0000) drop = 1'b1;
`endif
      if (drop) begin
        m_drv = 1'b0;
        m_w = first_from(a, m_ptr);
        m_left = DEAD;
      end else if (m_ten < 255) begin
        m_ten++;
      end
    end
  endtask

  // One clock: the model sees the same req_ the DUT sampled; return on negedge.
  task automatic tick();
    @(posedge clk);
    model_step(~req_);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_ = 4'b1111;
    clr_ = 1'b0;
    model_reset();
    #2;
    clr_ = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    req_ = 4'b0000;
    clr_ = 1'b0;
    #1;
    n_checks++; if (gnt_ !== 4'b1111) $display("FAIL reset_gnt: got %b expected 1111", gnt_); else n_pass++;
    n_checks++; if (oe_ !== 4'b1111) $display("FAIL reset_oe: got %b expected 1111", oe_); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (owner !== 2'd0) $display("FAIL reset_owner: got %0d expected 0", owner); else n_pass++;
    req_ = 4'b1111;
    #1;
    clr_ = 1'b1;
    model_reset();
  endtask

  task automatic test_single_grant();
    req_ = 4'b1110;
    tick();
    n_checks++; if (gnt_ !== 4'b1110 || oe_ !== 4'b1111 || busy !== 1'b1)
      $display("FAIL single_turn: got gnt_=%b oe_=%b busy=%b expected 1110 1111 1", gnt_, oe_, busy); else n_pass++;
    tick();
    n_checks++; if (gnt_ !== 4'b1110 || oe_ !== 4'b1110 || owner !== 2'd0)
      $display("FAIL single_own: got gnt_=%b oe_=%b owner=%0d expected 1110 1110 0", gnt_, oe_, owner); else n_pass++;
    req_ = 4'b1111;
    tick();
    n_checks++; if (gnt_ !== 4'b1111 || oe_ !== 4'b1111 || busy !== 1'b0)
      $display("FAIL single_release: got gnt_=%b oe_=%b busy=%b expected 1111 1111 0", gnt_, oe_, busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int own_cnt = 0;
    int gap = 0;
    int cyc = 0;
    int cur;
    bit prev_idle = 1'b1;
    bit restore = 1'b0;
    pulse_reset();
    req_ = 4'b0000;
    while (n < 5 && cyc < 80) begin
      tick();
      cyc++;
      if (restore) begin
        req_ = 4'b0000;
        restore = 1'b0;
      end
      n_checks++; if ($countones(~oe_) > 1) $display("FAIL rr_one_oe: got oe_=%b expected at most one low", oe_); else n_pass++;
      if (oe_ == 4'b1111) begin
        gap++;
        prev_idle = 1'b1;
      end else begin
        cur = first_from(~oe_, 0);
        if (prev_idle) begin
          n_checks++; if (cur != order[n]) $display("FAIL rr_order: got owner %0d expected %0d", cur, order[n]); else n_pass++;
          if (n > 0) begin
            n_checks++; if (gap != DEAD) $display("FAIL rr_gap: got %0d idle cycles expected %0d", gap, DEAD); else n_pass++;
          end
          n++;
          own_cnt = 0;
        end
        prev_idle = 1'b0;
        gap = 0;
        own_cnt++;
        if (own_cnt == 3) begin
          req_ = 4'b0001 << cur;
          restore = 1'b1;
        end
      end
    end
    n_checks++; if (n != 5) $display("FAIL rr_timeout: got %0d tenures expected 5", n); else n_pass++;
  endtask

  task automatic test_turn_abort();
    pulse_reset();
    req_ = 4'b1101;
    tick();
    n_checks++; if (gnt_ !== 4'b1101 || oe_ !== 4'b1111)
      $display("FAIL abort_turn: got gnt_=%b oe_=%b expected 1101 1111", gnt_, oe_); else n_pass++;
    req_ = 4'b1111;
    tick();
    n_checks++; if (gnt_ !== 4'b1111 || oe_ !== 4'b1111 || busy !== 1'b0)
      $display("FAIL abort_idle: got gnt_=%b oe_=%b busy=%b expected 1111 1111 0", gnt_, oe_, busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    req_ = 4'b1011;
    tick();
    tick();
    n_checks++; if (oe_ !== 4'b1011 || owner !== 2'd2)
      $display("FAIL areset_own: got oe_=%b owner=%0d expected 1011 2", oe_, owner); else n_pass++;
    #2;
    clr_ = 1'b0;
    model_reset();
    #1;
    n_checks++; if (oe_ !== 4'b1111 || gnt_ !== 4'b1111 || busy !== 1'b0)
      $display("FAIL areset_release: got oe_=%b gnt_=%b busy=%b expected 1111 1111 0", oe_, gnt_, busy); else n_pass++;
    req_ = 4'b0000;
    #1;
    clr_ = 1'b1;
    tick();
    n_checks++; if (gnt_ !== 4'b1110 || owner !== 2'd0)
      $display("FAIL areset_ptr: got gnt_=%b owner=%0d expected 1110 0", gnt_, owner); else n_pass++;
  endtask

`ifdef ARB_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    pulse_reset();
    req_ = 4'b1100;
    tick();
    for (int i = 0; i < MAXHOLD; i++) begin
      tick();
      n_checks++; if (oe_ !== 4'b1110) $display("FAIL hold_own0: cycle %0d got oe_=%b expected 1110", i, oe_); else n_pass++;
    end
    tick();
    n_checks++; if (oe_ !== 4'b1111 || gnt_ !== 4'b1101)
      $display("FAIL hold_preempt: got oe_=%b gnt_=%b expected 1111 1101", oe_, gnt_); else n_pass++;
    tick();
    n_checks++; if (oe_ !== 4'b1101) $display("FAIL hold_own1: got oe_=%b expected 1101", oe_); else n_pass++;
    pulse_reset();
    req_ = 4'b1110;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (oe_ !== 4'b1110) $display("FAIL hold_sole: cycle %0d got oe_=%b expected 1110", i, oe_); else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_oe;
    logic            e_busy;
    logic [OWNW-1:0] e_owner;
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 4) == 0) req_ = req_ ^ (4'b0001 << b);
      end
      tick();
      e_gnt   = (m_w < 0) ? 4'b1111 : ~(4'b0001 << m_w);
      e_oe    = m_drv ? ~(4'b0001 << m_w) : 4'b1111;
      e_busy  = (m_w >= 0);
      e_owner = (m_w < 0) ? 2'd0 : 2'(m_w);
      n_checks++;
      if (gnt_ !== e_gnt || oe_ !== e_oe || busy !== e_busy || owner !== e_owner)
        $display("FAIL rand_model: cycle %0d req_=%b got gnt_=%b oe_=%b busy=%b owner=%0d expected %b %b %b %0d",
                 c, req_, gnt_, oe_, busy, owner, e_gnt, e_oe, e_busy, e_owner);
      else n_pass++;
      n_checks++;
      if ($countones(~gnt_) > 1 || $countones(~oe_) > 1 || ((~oe_ & gnt_) != 4'b0000))
        $display("FAIL rand_invariant: cycle %0d got gnt_=%b oe_=%b expected one-hot-low with oe under gnt", c, gnt_, oe_);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_turn_abort();
    test_async_reset();
`ifdef ARB_HOLD_LIMIT_EN
    test_hold_limit();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
